sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Upstream conditioning stage for the slide-switch PIO.
- Takes the raw, asynchronous switch pins from the board.
- Synchronises each bit into the clk domain and debounces it with a per-bit stability counter.
- Drives the clean bus onto the PIO's in_port. Also provides per-bit rise/fall/change strobes for interrupt or edge-capture logic.

Parameters:
- WIDTH, 10, number of switch bits; must equal the PIO in_port width.
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronised bit must differ from its debounced value before it is accepted (1 ms at 50 MHz); legal range 1 .. 2**CNT_W.
- CNT_W, 16, width of each per-bit stability counter.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; asserts immediately and releases on clk.
- sw_raw  input  WIDTH  raw switch pins; asynchronous to clk.
- sw_debounced  output  WIDTH  debounced switch state; connects to PIO in_port.
- sw_rise  output  WIDTH  one-cycle strobe per bit on an accepted 0->1 change.
- sw_fall  output  WIDTH  one-cycle strobe per bit on an accepted 1->0 change.
- sw_changed  output  1  one-cycle strobe; OR of sw_rise|sw_fall.

Behaviour:
- Reset (reset_n=0, asynchronous): sync stages, counters, sw_debounced, sw_rise, sw_fall and sw_changed all become 0.
- Synchroniser: two flops per bit, s1<=sw_raw, s2<=s1. Only s2 is used downstream. No logic on sw_raw or s1.
- Per-bit rule, evaluated each clk edge, with mismatch = s2[i] != sw_debounced[i]:
  - mismatch and cnt[i]==DEBOUNCE_CYCLES-1: sw_debounced[i]<=s2[i], cnt[i]<=0, sw_rise[i]<=s2[i], sw_fall[i]<=~s2[i].
  - mismatch otherwise: cnt[i]<=cnt[i]+1, strobes 0.
  - no mismatch: cnt[i]<=0, strobes 0.
- Bits are fully independent; any number of bits may be accepted on the same edge.
- sw_changed is registered on the same edge as the strobes, equal to |(next sw_rise | next sw_fall), so it is coincident with them.
- Latency: sw_raw stable from edge k (first edge sampling the new level):
  - s2 updates at edge k+1.
  - sw_debounced and the strobe update at edge k+1+DEBOUNCE_CYCLES.
  - The strobe is high for exactly the following cycle.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles at s2 returns cnt to 0. There is no output change and no strobe; partial counts are never retained.
- Bounce during counting: any single cycle of agreement restarts the count from 0.
- DEBOUNCE_CYCLES=1: every s2 change is accepted on the next edge (pure 2-flop sync plus 1-cycle register).
- Counter never wraps: it is reset at DEBOUNCE_CYCLES-1 on acceptance, or on agreement.
- Power-up: sw_debounced resets to 0. Any switch held at 1 through reset produces a normal sw_rise/sw_changed strobe DEBOUNCE_CYCLES+2 edges after reset release. This is intentional; software sees the initial state as edges.
- Reset mid-count: all counts discarded, outputs to 0 immediately (asynchronous), count restarts after release.
- Outputs are pure registers with no combinational path from sw_raw.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=10):
- Reset, then sw_raw=0x000 for 20 cycles -> sw_debounced=0x000, all strobes 0 throughout.
- sw_raw 0x000->0x001 at edge k, held -> sw_debounced=0x001 from edge k+5; sw_rise=0x001 and sw_changed=1 for exactly one cycle; sw_fall=0.
- Bit 3 glitch: sw_raw[3] high for 3 cycles, then low -> sw_debounced[3] stays 0, no strobes. Repeat with a 4-cycle pulse -> accepted, then a fall is accepted 5 cycles after the pulse ends.
- Bounce: sw_raw[5] toggles 1,0,1,1,1,1 on consecutive edges -> acceptance occurs 4 cycles after the final stable-high run reaches s2, not earlier.
- Simultaneous: sw_raw 0x001->0x300 on one edge -> on one edge sw_debounced=0x300, sw_rise=0x300, sw_fall=0x001, sw_changed=1.
- sw_raw=0x3FF held through reset; reset_n pulsed low mid-count for 1 cycle -> outputs clear asynchronously; sw_debounced=0x3FF and sw_rise=0x3FF 6 edges after release.

Source files
------------

// File: rtl/sw_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_if
// Description : Switch conditioning bus. Raw board pins in, debounced level
//               plus per-bit edge strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_debounce_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_debounced;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    // Board / PIO side: supplies raw pins, consumes the clean bus.
    modport master (
        output sw_raw,
        input  sw_debounced,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Debouncer side.
    modport slave (
        input  sw_raw,
        output sw_debounced,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchroniser plus per-bit stability-counter
//               debouncer for the slide-switch PIO, with registered
//               rise/fall/change strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    sw_debounce_if.slave  sw_bus
);

    // Count value at which a still-mismatching bit is accepted.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_mismatch;
    logic [WIDTH-1:0] w_deb_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    // Two-stage synchroniser; only r_s2 feeds the debounce logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_bus.sw_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-bit acceptance rule: a mismatch must persist for DEBOUNCE_CYCLES
    // consecutive edges; any agreement drops the count back to zero.
    always_comb begin
        w_mismatch = r_s2 ^ r_deb;
        w_deb_nxt  = r_deb;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (w_mismatch[i]) begin
                if (r_cnt[i] == c_CNT_LAST) begin
                    w_deb_nxt[i]  = r_s2[i];
                    w_rise_nxt[i] = r_s2[i];
                    w_fall_nxt[i] = ~r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounced state, counters and strobes; all outputs are pure registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb     <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_deb     <= w_deb_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_changed <= |(w_rise_nxt | w_fall_nxt);
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign sw_bus.sw_debounced = r_deb;
    assign sw_bus.sw_rise      = r_rise;
    assign sw_bus.sw_fall      = r_fall;
    assign sw_bus.sw_changed   = r_changed;

endmodule
`default_nettype wire
